// File: rtl/parity_serial_framer_if.sv
// Producer-to-framer word handshake plus the framer's serial-line status outputs.
interface parity_serial_framer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ser_out;
    logic              busy;
    logic              par_bit;
    logic              frame_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, busy, par_bit, frame_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, busy, par_bit, frame_done
    );
endinterface

// File: rtl/parity_serial_framer.sv
// Serializes parallel words LSB-first as start/data/parity/stop frames,
// accumulating parity one XOR per shifted data bit.
module parity_serial_framer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    parity_serial_framer_if.slave  bus
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic              ser_q, ser_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              par_q, par_d;
    logic              done_q, done_d;
    logic              last_tick;

    assign last_tick = (tick_q == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        par_d   = par_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ser_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && ready_q) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = bus.in_data;
                    acc_d   = (ODD_PARITY != 0);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (last_tick) begin
                    state_d = DATA;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    tick_d  = '0;
                    acc_d   = acc_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = PARITY;
                        par_d   = acc_d;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            PARITY: begin
                if (last_tick) begin
                    state_d = STOP;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so the output stays registered.
        case (state_d)
            START:   ser_d = 1'b0;
            DATA:    ser_d = shift_d[0];
            PARITY:  ser_d = acc_d;
            default: ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            ser_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            ser_q   <= ser_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.ser_out    = ser_q;
    assign bus.busy       = busy_q;
    assign bus.par_bit    = par_q;
    assign bus.frame_done = done_q;
endmodule
